// File: rtl/fib_pkg.sv
// Shared constants for the Fibonacci history display: digit count, widths,
// the blank segment pattern and the active-low hex glyph table.
package fib_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned HEX_W      = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned CNT_W      = 8;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Segment order {g,f,e,d,c,b,a}, active-low; entry 15 is leftmost.
    localparam logic [15:0][SEG_W-1:0] GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
        7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment glyph decode.
module hex7seg
    import fib_pkg::*;
(
    input  logic [HEX_W-1:0] hex,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = GLYPH[hex];

endmodule

// File: rtl/fib_display.sv
// Captures the last eight Fibonacci terms on each en strobe and scans them
// onto a multiplexed eight-digit seven-segment display.
module fib_display
    import fib_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [HEX_W-1:0]      fn,
    input  logic                  clr,
    output logic [NUM_DIGITS-1:0] an,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic [CNT_W-1:0]      cnt,
    output logic                  wrap
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);

    logic [NUM_DIGITS-1:0][HEX_W-1:0] hist;
    logic [NUM_DIGITS-1:0]            mask;
    logic [DIV_W-1:0]                 div;
    logic [IDX_W-1:0]                 idx;
    logic [SEG_W-1:0]                 glyph_c;
    logic                             shown_c;

    // Sample history, fill mask, saturating count and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            mask <= '0;
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (clr) begin
            hist <= '0;
            mask <= '0;
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (en) begin
            hist <= {hist[NUM_DIGITS-2:0], fn};
            mask <= {mask[NUM_DIGITS-2:0], 1'b1};
            if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
            // A smaller term than the previous one means the 4-bit sum overflowed.
            if ((cnt != '0) && (fn < hist[0])) begin
                wrap <= 1'b1;
            end
        end
    end

    // Digit scan timebase; independent of capture and clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
        end else if (div == DIV_W'(SCAN_DIV - 1)) begin
            div <= '0;
            idx <= idx + IDX_W'(1);
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    hex7seg u_hex7seg (
        .hex   (hist[idx]),
        .seg_c (glyph_c)
    );

    assign shown_c = mask[idx];

    // Registered display drive; unfilled slots stay dark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= shown_c ? ~(NUM_DIGITS'(1) << idx) : '1;
            seg <= shown_c ? glyph_c : SEG_BLANK;
            dp  <= ~(wrap && (idx == '0) && shown_c);
        end
    end

endmodule

// File: tb/tb_fib_display.sv
// Directed bench for fib_display with a fast scan divider.
module tb_fib_display;

    localparam int unsigned SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] fn;
    logic       clr;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [7:0] cnt;
    logic       wrap;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    logic [3:0] m_hist [8];
    logic [7:0] m_mask;
    logic [7:0] m_cnt;
    logic       m_wrap;

    fib_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .fn   (fn),
        .clr  (clr),
        .an   (an),
        .seg  (seg),
        .dp   (dp),
        .cnt  (cnt),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic m_reset();
        for (int k = 0; k < 8; k++) m_hist[k] = 4'h0;
        m_mask = 8'h00;
        m_cnt  = 8'h00;
        m_wrap = 1'b0;
    endtask

    // One en pulse; expected state follows the documented capture rules.
    task automatic capture(input logic [3:0] v);
        @(negedge clk);
        fn = v;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        if (m_cnt != 8'h00 && v < m_hist[0]) m_wrap = 1'b1;
        for (int k = 7; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = v;
        m_mask = {m_mask[6:0], 1'b1};
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'h01;
    endtask

    task automatic wait_an(input string tag, input logic [7:0] target);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (an === target) found = 1'b1;
        end
        chk({tag, "_reach"}, 32'(found), 32'd1);
    endtask

    // Watch more than one full scan period and check every slot shown.
    task automatic scan(input string tag);
        logic [7:0] seen;
        bit         hit;
        seen = 8'h00;
        repeat (40) begin
            @(negedge clk);
            if (an === 8'hFF) begin
                chk({tag, "_blank"}, 32'({seg, dp}), 32'({7'h7F, 1'b1}));
            end else begin
                hit = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    if (an === ~(8'h01 << k)) begin
                        hit     = 1'b1;
                        seen[k] = 1'b1;
                        chk({tag, "_digit"}, 32'({seg, dp}),
                            32'({glyph(m_hist[k]), !(m_wrap && k == 0)}));
                    end
                end
                chk({tag, "_onehot"}, 32'(hit), 32'd1);
            end
        end
        chk({tag, "_seen"}, 32'(seen), 32'(m_mask));
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        clr = 1'b0;
        fn  = 4'h0;
        m_reset();
        #1;
        chk("reset_out", 32'({an, seg, dp, cnt, wrap}), 32'({8'hFF, 7'h7F, 1'b1, 8'h00, 1'b0}));
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset: display stays dark.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            chk("idle", 32'({an, seg, dp, cnt, wrap}), 32'({8'hFF, 7'h7F, 1'b1, 8'h00, 1'b0}));
        end

        // First six Fibonacci terms.
        capture(4'd1); capture(4'd1); capture(4'd2);
        capture(4'd3); capture(4'd5); capture(4'd8);
        chk("cnt6", 32'(cnt), 32'd6);
        chk("wrap6", 32'(wrap), 32'd0);
        scan("fill6");
        wait_an("idx0", 8'hFE);
        chk("idx0_seg", 32'(seg), 32'h00);
        wait_an("idx5", 8'hDF);
        chk("idx5_seg", 32'(seg), 32'h79);

        // 13 then 21 mod 16 = 5: overflow detected.
        capture(4'd13);
        chk("wrap13", 32'(wrap), 32'd0);
        capture(4'd5);
        chk("wrap5", 32'(wrap), 32'd1);
        chk("cnt8", 32'(cnt), 32'd8);
        scan("wrapped");
        wait_an("dp_idx0", 8'hFE);
        chk("dp_idx0", 32'({seg, dp}), 32'({7'h12, 1'b0}));
        wait_an("dp_idx1", 8'hFD);
        chk("dp_idx1", 32'({seg, dp}), 32'({7'h21, 1'b1}));

        // Clear wins over a simultaneous capture.
        @(negedge clk);
        clr = 1'b1;
        en  = 1'b1;
        fn  = 4'd9;
        @(negedge clk);
        clr = 1'b0;
        en  = 1'b0;
        m_reset();
        chk("clr_cnt", 32'(cnt), 32'd0);
        chk("clr_wrap", 32'(wrap), 32'd0);
        chk("clr_mask", 32'(dut.mask), 32'd0);
        @(negedge clk);
        chk("clr_an", 32'(an), 32'hFF);
        scan("cleared");
        capture(4'd2);
        chk("post_clr_cnt", 32'(cnt), 32'd1);
        wait_an("post_clr_idx0", 8'hFE);
        chk("post_clr_seg", 32'(seg), 32'h24);
        scan("post_clr");

        // Long run: count saturates, history keeps the last eight.
        for (int i = 0; i < 300; i++) capture(4'(i));
        chk("cnt_sat", 32'(cnt), 32'd255);
        chk("wrap_sat", 32'(wrap), 32'd1);
        wait_an("sat_idx0", 8'hFE);
        chk("sat_idx0_seg", 32'(seg), 32'h03);
        wait_an("sat_idx7", 8'h7F);
        chk("sat_idx7_seg", 32'(seg), 32'h19);
        scan("saturated");

        // Asynchronous reset between edges.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst", 32'({an, seg, dp, cnt, wrap}), 32'({8'hFF, 7'h7F, 1'b1, 8'h00, 1'b0}));
        #1 rst = 1'b0;
        m_reset();
        capture(4'd0);
        chk("rst_cap_wrap", 32'(wrap), 32'd0);
        chk("rst_cap_cnt", 32'(cnt), 32'd1);
        wait_an("rst_idx0", 8'hFE);
        chk("rst_idx0_seg", 32'({seg, dp}), 32'({7'h40, 1'b1}));
        scan("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fib_display.md
FIB_DISPLAY -- requirements
Module: fib_display

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles per display digit slot (minimum 2).
REQ-002 The block SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port en  input  1  sample strobe, same signal that advances the upstream Fibonacci generator.
REQ-005 The block SHALL have port fn  input  4  current Fibonacci term from upstream, unsigned.
REQ-006 The block SHALL have port clr  input  1  synchronous clear of history, count and wrap flag.
REQ-007 The block SHALL have port an  output  8  digit enables, active-low, one-hot.
REQ-008 The block SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 The block SHALL have port dp  output  1  decimal point, active-low.
REQ-010 The block SHALL have port cnt  output  8  number of samples captured, saturating.
REQ-011 The block SHALL have port wrap  output  1  sticky flag: a 4-bit overflow was seen in the sequence.

Function
REQ-012 History SHALL be 8 x 4-bit entries, hist[0] newest; on a rising edge with en=1 and clr=0, hist[k] <= hist[k-1] for k=1..7 and hist[0] <= fn.
REQ-013 Sample-to-history latency SHALL be 1 cycle; the captured value is fn as sampled on that edge.
REQ-014 An 8-bit fill mask SHALL shift in a 1 on every capture; digits with mask bit 0 are blanked (an bit held 1).
REQ-015 cnt SHALL increment by 1 per capture and saturate at 255.
REQ-016 wrap SHALL set on a capture where cnt>=1 and fn < hist[0] (unsigned), and stay set until clr or rst.
REQ-017 clr=1 SHALL zero history, mask, cnt and wrap on the next edge; clr and en in the same cycle: clr wins, no capture.
REQ-018 A divider SHALL count 0..SCAN_DIV-1 and wrap; at terminal count digit index idx (3-bit) SHALL advance, 7 wrapping to 0.
REQ-019 an, seg, dp SHALL be registered, reflecting idx and history 1 cycle after either changes.
REQ-020 an SHALL be ~(1<<idx) when mask[idx]=1, else 8'hFF; seg SHALL be the hex glyph of hist[idx] when shown, else 7'h7F.
REQ-021 Glyphs SHALL be 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,B=03,C=46,D=21,E=06,F=0E (hex).
REQ-022 dp SHALL be 0 only when wrap=1 and idx=0 and digit 0 is shown; otherwise 1.
REQ-023 clr and en SHALL NOT disturb the divider or idx.

Reset
REQ-024 On rst=1, immediately and independent of clk: hist=0, mask=0, cnt=0, wrap=0, divider=0, idx=0, an=8'hFF, seg=7'h7F, dp=1.
REQ-025 Reset asserted mid-scan or mid-capture SHALL discard all state; first capture after release SHALL behave as capture #1 (no wrap check).

Structure
REQ-026 NUM_DIGITS=8, the blank value 7'h7F and the glyph table SHALL live in the shared package fib_pkg.
REQ-027 The hex-to-segment decode SHALL be a combinational sub-module hex7seg (4-bit in, 7-bit active-low out).
REQ-028 The block SHALL be 120-400 lines of RTL, with no latches and a single clock domain.

Verification (SCAN_DIV=4 in simulation)
REQ-029 Reset then no en for 64 cycles -> an=FF, seg=7F, dp=1, cnt=0, wrap=0 throughout.
REQ-030 Feed 1,1,2,3,5,8 with en pulses -> cnt=6, hist[0..5]=8,5,3,2,1,1; when idx=0 the outputs are an=FE, seg=00; idx=6,7 keep an=FF.
REQ-031 Continue with 13 then 5 (21 mod 16) -> wrap=1 after the 5-capture; dp=0 only in the idx=0 slot.
REQ-032 clr and en together with fn=9 -> next cycle cnt=0, wrap=0, mask=0, an=FF; the 9 is not captured.
REQ-033 300 captures -> cnt holds at 255; history holds the last 8 values.
REQ-034 rst pulsed asynchronously between edges mid-scan -> outputs reach reset values before the next edge; the next capture does not set wrap.
